// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multi-cycle RV32M multiply/divide unit beside the EX-stage ALU.
// Ports: clk, reset (async, active-low); start/Funct3/op_a/op_b/flush in;
//   busy (stall request), done (1-cycle pulse), result (registered) out.
// Optional: define MULDIV_FAST_MUL_EN for a single-cycle combinational MUL*.
module muldiv_sequencer #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      Funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int CNT_W = $clog2(XLEN);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [2:0]        f3_q, f3_d;
    logic              neg_q, neg_d;
    logic              rneg_q, rneg_d;
    logic [XLEN-1:0]   hi_q, hi_d;
    logic [XLEN-1:0]   lo_q, lo_d;
    logic [XLEN-1:0]   b_q, b_d;
    logic [XLEN-1:0]   res_q, res_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              accept;
    logic              a_s, b_s, a_neg, b_neg;
    logic [XLEN-1:0]   abs_a, abs_b;
    logic              div0, ovf;
    logic [XLEN-1:0]   spec_res;
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_t, div_diff;
    logic              div_ok;
    logic [XLEN-1:0]   step_hi, step_lo;
    logic [2*XLEN-1:0] prod, prod_fix;
    logic [XLEN-1:0]   mul_word, quo, rem, div_word;

    assign accept = start & ~flush & reset;

    // Signedness of each operand, derived from Funct3.
    assign a_s   = Funct3[2] ? ~Funct3[0] : (Funct3[1:0] != 2'b11);
    assign b_s   = Funct3[2] ? ~Funct3[0] : ~Funct3[1];
    assign a_neg = a_s & op_a[XLEN-1];
    assign b_neg = b_s & op_b[XLEN-1];
    assign abs_a = a_neg ? (~op_a + 1'b1) : op_a;
    assign abs_b = b_neg ? (~op_b + 1'b1) : op_b;

    assign div0 = Funct3[2] && (op_b == '0);
    assign ovf  = Funct3[2] && !Funct3[0] && (op_b == '1)
               && (op_a == {1'b1, {(XLEN-1){1'b0}}});

    always_comb begin
        if (div0) spec_res = Funct3[1] ? op_a : '1;
        else      spec_res = Funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    end

    // One iteration: shift-add multiply (hi:lo = acc:multiplier)
    // or restoring divide (hi:lo = remainder:dividend/quotient).
    assign mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    assign div_t    = {hi_q, lo_q[XLEN-1]};
    assign div_diff = div_t - {1'b0, b_q};
    assign div_ok   = ~div_diff[XLEN];

    always_comb begin
        if (f3_q[2]) begin
            step_hi = div_ok ? div_diff[XLEN-1:0] : div_t[XLEN-1:0];
            step_lo = {lo_q[XLEN-2:0], div_ok};
        end else begin
            step_hi = mul_sum[XLEN:1];
            step_lo = {mul_sum[0], lo_q[XLEN-1:1]};
        end
    end

    // The last iteration is folded into FIX, so FIX sees the full result.
    assign prod     = {step_hi, step_lo};
    assign prod_fix = neg_q ? (~prod + 1'b1) : prod;
    assign mul_word = (f3_q[1:0] == 2'b00) ? prod_fix[XLEN-1:0]
                                           : prod_fix[2*XLEN-1:XLEN];
    assign quo      = neg_q ? (~step_lo + 1'b1) : step_lo;
    assign rem      = rneg_q ? (~step_hi + 1'b1) : step_hi;
    assign div_word = f3_q[1] ? rem : quo;

`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] fa, fb, fprod;
    logic [XLEN-1:0]   fast_word;
    assign fa        = {{XLEN{a_neg}}, op_a};
    assign fb        = {{XLEN{b_neg}}, op_b};
    assign fprod     = fa * fb;
    assign fast_word = (Funct3[1:0] == 2'b00) ? fprod[XLEN-1:0]
                                              : fprod[2*XLEN-1:XLEN];
`endif

    always_comb begin
        state_d = state_q;
        f3_d    = f3_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        b_d     = b_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        busy    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    busy   = 1'b1;
                    f3_d   = Funct3;
                    neg_d  = a_neg ^ b_neg;
                    rneg_d = a_neg;
                    cnt_d  = CNT_W'(XLEN-2);
                    if (div0 || ovf) begin
                        res_d   = spec_res;
                        state_d = S_DONE;
                    end
`ifdef MULDIV_FAST_MUL_EN
                    else if (!Funct3[2]) begin
                        res_d   = fast_word;
                        state_d = S_DONE;
                    end
`endif
                    else begin
                        hi_d    = '0;
                        lo_d    = Funct3[2] ? abs_a : abs_b;
                        b_d     = Funct3[2] ? abs_b : abs_a;
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                busy = 1'b1;
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    hi_d  = step_hi;
                    lo_d  = step_lo;
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == '0) state_d = S_FIX;
                end
            end
            S_FIX: begin
                busy = 1'b1;
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    res_d   = f3_q[2] ? div_word : mul_word;
                    state_d = S_DONE;
                end
            end
            S_DONE: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            f3_q    <= '0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            b_q     <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            f3_q    <= f3_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            b_q     <= b_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
        end
    end

    assign done   = (state_q == S_DONE);
    assign result = res_q;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: directed and random checks of muldiv_sequencer
// against an arithmetic reference model.
module tb_muldiv_sequencer;
    localparam logic [31:0] MINV = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  Funct3 = 3'd0;
    logic [31:0] op_a = 32'd0;
    logic [31:0] op_b = 32'd0;
    logic        busy, done;
    logic [31:0] result;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] last_res = 32'd0;

    always #5 clk = ~clk;

    muldiv_sequencer #(.XLEN(32)) dut (
        .clk(clk), .reset(reset), .start(start), .Funct3(Funct3),
        .op_a(op_a), .op_b(op_b), .flush(flush),
        .busy(busy), .done(done), .result(result)
    );

    function automatic logic [31:0] ref_res(input logic [2:0] f,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        longint sa, sb, ua, ub, q;
        logic [63:0] p;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'd0, a};
        ub = {32'd0, b};
        p  = 64'd0;
        q  = 0;
        case (f)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                q = sa / sb; return q[31:0];
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 0) return a;
                q = sa % sb; return q[31:0];
            end
            default: begin
                if (b == 0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] f,
                                   input logic [31:0] a,
                                   input logic [31:0] b);
        if (f[2] && b == 0) return 1;
        if (f[2] && !f[0] && a == MINV && b == 32'hFFFF_FFFF) return 1;
`ifdef MULDIV_FAST_MUL_EN
        if (!f[2]) return 1;
`endif
        return 33;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input bit flush_done,
                          input bit use_exp, input logic [31:0] exp_in);
        logic [31:0] exp;
        int lat;
        exp = use_exp ? exp_in : ref_res(f, a, b);
        lat = ref_lat(f, a, b);
        @(negedge clk);
        start = 1'b1; Funct3 = f; op_a = a; op_b = b; flush = 1'b0;
        #1;
        check($sformatf("busy f%0d c0", f), 32'(busy), 32'd1);
        check($sformatf("done f%0d c0", f), 32'(done), 32'd0);
        for (int k = 1; k <= lat + 1; k++) begin
            @(negedge clk);
            if (k == lat) begin
                start = 1'b1; Funct3 = 3'd5; op_a = $urandom;
                op_b = 32'd3; flush = flush_done;
            end else if (k == lat + 1) begin
                start = 1'b0; flush = 1'b0;
            end else begin
                start = (k == 3); Funct3 = 3'($urandom);
                op_a = $urandom; op_b = $urandom;
            end
            #1;
            check($sformatf("busy f%0d c%0d", f, k), 32'(busy), 32'(k < lat));
            check($sformatf("done f%0d c%0d", f, k), 32'(done), 32'(k == lat));
            if (k >= lat)
                check($sformatf("result f%0d %h %h c%0d", f, a, b, k),
                      result, exp);
        end
        last_res = exp;
    endtask

    initial begin
        logic [2:0]  rf;
        logic [31:0] ra, rb;
        int          sel;

        #1;
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset result", result, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 0, 1, 32'hFFFF_FFEB);
        run_op(3'd1, MINV, MINV, 0, 1, 32'h4000_0000);
        run_op(3'd3, MINV, MINV, 0, 1, 32'h4000_0000);
        run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 0, 1, 32'hFFFF_FFFF);
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 0, 1, 32'hFFFF_FFFD);
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 0, 1, 32'hFFFF_FFFF);
        run_op(3'd5, 32'd100, 32'd7, 0, 1, 32'd14);
        run_op(3'd7, 32'd100, 32'd7, 0, 1, 32'd2);
        run_op(3'd5, 32'd5, 32'd0, 0, 1, 32'hFFFF_FFFF);
        run_op(3'd7, 32'd5, 32'd0, 0, 1, 32'd5);
        run_op(3'd4, MINV, 32'hFFFF_FFFF, 0, 1, MINV);
        run_op(3'd6, MINV, 32'hFFFF_FFFF, 0, 1, 32'd0);
        run_op(3'd4, 32'd9, 32'd0, 0, 1, 32'hFFFF_FFFF);
        run_op(3'd6, 32'hFFFF_FFF9, 32'd0, 0, 1, 32'hFFFF_FFF9);
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 1, 32'hFFFF_FFFE);

        // Flush mid-divide: op abandoned, result held, next op starts.
        @(negedge clk);
        start = 1'b1; Funct3 = 3'd4; op_a = 32'd1000; op_b = 32'd7;
        #1;
        check("flush busy c0", 32'(busy), 32'd1);
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            start = 1'b0; flush = (k == 10);
            #1;
            check($sformatf("flush busy c%0d", k), 32'(busy), 32'(k <= 10));
            check($sformatf("flush done c%0d", k), 32'(done), 32'd0);
        end
        check("flush result held", result, last_res);
        flush = 1'b0;
        run_op(3'd0, 32'd3, 32'd4, 0, 1, 32'd12);

        // Flush together with start in IDLE: nothing accepted.
        @(negedge clk);
        start = 1'b1; flush = 1'b1; Funct3 = 3'd5; op_a = 32'd50; op_b = 32'd5;
        #1;
        check("idle flush busy", 32'(busy), 32'd0);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            start = 1'b0; flush = 1'b0;
            #1;
            check($sformatf("idle flush busy c%0d", k), 32'(busy), 32'd0);
            check($sformatf("idle flush done c%0d", k), 32'(done), 32'd0);
        end
        check("idle flush result", result, last_res);

        // Asynchronous reset in the middle of a divide.
        @(negedge clk);
        start = 1'b1; Funct3 = 3'd4; op_a = 32'd77; op_b = 32'd5;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k == 5) reset = 1'b0;
        end
        #1;
        check("midreset busy", 32'(busy), 32'd0);
        check("midreset done", 32'(done), 32'd0);
        check("midreset result", result, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("post reset busy", 32'(busy), 32'd0);
        run_op(3'd5, 32'd9, 32'd3, 0, 1, 32'd3);

        for (int i = 0; i < 40; i++) begin
            rf  = 3'($urandom_range(0, 7));
            sel = $urandom_range(0, 5);
            ra  = $urandom;
            rb  = $urandom;
            if (sel == 0) rb = 32'd0;
            else if (sel == 1) begin ra = MINV; rb = 32'hFFFF_FFFF; end
            else if (sel == 2) begin
                ra = 32'($signed(8'($urandom)));
                rb = 32'($urandom_range(1, 20));
            end
            run_op(rf, ra, rb, (i % 7) == 3, 0, 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
